// File: rtl/csr_types.sv
// Shared CSR-side definitions for the interrupt source unit.
// Contains the machine interrupt cause codes, the source FSM states and the
// fixed-priority cause encoder.
package csr_types;

    localparam logic [4:0] INT_CODE_NONE = 5'd0;
    localparam logic [4:0] INT_CODE_MSI  = 5'd3;
    localparam logic [4:0] INT_CODE_MTI  = 5'd7;
    localparam logic [4:0] INT_CODE_MEI  = 5'd11;

    typedef enum logic [1:0] {
        IS_IDLE      = 2'd0,
        IS_REQUESTED = 2'd1,
        IS_TAKEN     = 2'd2
    } interrupt_src_state_t;

    // Highest-priority enabled source; en = {mei, msi, mti}, MEI > MSI > MTI.
    function automatic logic [4:0] interrupt_sel_code(input logic [2:0] en);
        logic [4:0] code;
        if (en[2]) begin
            code = INT_CODE_MEI;
        end else if (en[1]) begin
            code = INT_CODE_MSI;
        end else if (en[0]) begin
            code = INT_CODE_MTI;
        end else begin
            code = INT_CODE_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/mtimer.sv
// Machine timer: prescaler, free-running 64-bit mtime, software-written
// mtimecmp and the registered mtime >= mtimecmp compare.
module mtimer #(
    parameter int TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [63:0] mtime,
    output logic        mtip
);

    // A one-bit prescaler is kept even for TIMER_DIV = 1; it simply stays at 0.
    localparam int            PW         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [63:0]   mtime_q;
    logic [63:0]   mtimecmp_q;
    logic          mtip_q;

    // Prescaler counts 0..TIMER_DIV-1; mtime steps when it wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            mtime_q <= mtime_q + 64'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Compare register, written one 32-bit half at a time; resets to all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_q <= '1;
        end else if (reg_we && (reg_addr == 2'd0)) begin
            mtimecmp_q[31:0] <= reg_wdata;
        end else if (reg_we && (reg_addr == 2'd1)) begin
            mtimecmp_q[63:32] <= reg_wdata;
        end
    end

    // Registered unsigned compare keeps the wide comparator off the request path.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip_q <= 1'b0;
        end else begin
            mtip_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mtime = mtime_q;
    assign mtip  = mtip_q;

endmodule

// File: rtl/interrupt_source_unit.sv
// Machine-mode interrupt source unit: synchronizes the external line, holds
// msip, owns the machine timer and raises one prioritized request to gc.
//
//   state        | meaning
//   IS_IDLE      | no request presented; waits for an enabled source
//   IS_REQUESTED | interrupt_pending high; code tracks the best source
//   IS_TAKEN     | gc accepted; code frozen until gc captures the trap PC
module interrupt_source_unit
    import csr_types::*;
#(
    parameter int TIMER_DIV   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq_async,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        mie_msie,
    input  logic        interrupt_taken,
    input  logic        interrupt_pc_capture,
    output logic        interrupt_pending,
    output logic [4:0]  interrupt_code,
    output logic        mip_meip,
    output logic        mip_mtip,
    output logic        mip_msip,
    output logic [63:0] mtime
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   msip_q;
    logic [2:0]             en;
    logic                   req;
    logic [4:0]             sel_code;
    interrupt_src_state_t   state_q, state_d;
    logic [4:0]             code_q, code_d;

    mtimer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_mtimer (
        .clk       (clk),
        .rst       (rst),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .mtime     (mtime),
        .mtip      (mip_mtip)
    );

    // Multi-flop synchronizer for the asynchronous external interrupt level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_async};
        end
    end

    assign mip_meip = sync_q[SYNC_STAGES-1];

    // Software interrupt bit, written at register address 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
        end else if (reg_we && (reg_addr == 2'd2)) begin
            msip_q <= reg_wdata[0];
        end
    end

    assign mip_msip = msip_q;
    assign en       = {mip_meip & mie_meie, msip_q & mie_msie, mip_mtip & mie_mtie};
    assign req      = mstatus_mie & (|en);
    assign sel_code = interrupt_sel_code(en);

    // FSM state and presented cause code registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IS_IDLE;
            code_q  <= INT_CODE_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Next state / next code. A take in the same cycle the request withdraws
    // still wins: gc has already committed to the code it saw.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IS_IDLE: begin
                if (req) begin
                    state_d = IS_REQUESTED;
                    code_d  = sel_code;
                end
            end
            IS_REQUESTED: begin
                if (interrupt_taken && interrupt_pc_capture) begin
                    state_d = IS_IDLE;
                end else if (interrupt_taken) begin
                    state_d = IS_TAKEN;
                end else if (!req) begin
                    state_d = IS_IDLE;
                end else begin
                    code_d = sel_code;
                end
            end
            IS_TAKEN: begin
                if (interrupt_pc_capture) begin
                    state_d = IS_IDLE;
                end
            end
            default: begin
                state_d = IS_IDLE;
            end
        endcase
    end

    assign interrupt_pending = (state_q == IS_REQUESTED);
    assign interrupt_code    = code_q;

endmodule
